rot_tile_buffer: RTL and testbench

Parametrised tile buffer for the rotation engine. It sits between the AHB DMA read path and the DMA write path, clocked by I_HCLK. Each run accepts one TILE_N×TILE_N tile of pixels in raster order, then emits it in raster order rotated by 0/90/180/270 degrees clockwise. Mode is selected per tile, and an optional horizontal flip can be compiled in.

---
 rtl/rot_pkg.sv | 30 +++
 rtl/rot_addr_map.sv | 71 +++++++
 rtl/rot_tile_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_rot_tile_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotation tile buffer and its address mapper:
// rotation mode encoding, FSM state encoding and a log2 helper.
package rot_pkg;

    // Rotation modes, clockwise
    localparam logic [1:0] ROT_MODE_0   = 2'd0;
    localparam logic [1:0] ROT_MODE_90  = 2'd1;
    localparam logic [1:0] ROT_MODE_180 = 2'd2;
    localparam logic [1:0] ROT_MODE_270 = 2'd3;

    // Tile buffer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } rot_state_e;

    // Ceiling log2, used to size the row/column fields of a tile index
    function automatic int rot_log2(input int value);
        int result;
        result = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) begin
                result = b + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rot_addr_map.sv
// Combinational output-position to source-index mapper for one tile.
// (i, j) is the raster position of the output pixel; src_idx = row*N + col
// is where that pixel sits in the raster-ordered input tile.
// Optional feature macro: ROT_TILE_FLIP_EN adds the flip input, which
// mirrors j before the rotation is applied.
module rot_addr_map
    import rot_pkg::*;
#(
    parameter int LOG_N = 3
)(
    input  logic [LOG_N-1:0]   i,
    input  logic [LOG_N-1:0]   j,
    input  logic [1:0]         mode,
`ifdef ROT_TILE_FLIP_EN
    input  logic               flip,
`endif
    output logic [2*LOG_N-1:0] src_idx
);

    logic [LOG_N-1:0] j_eff;
    logic [LOG_N-1:0] i_inv;
    logic [LOG_N-1:0] j_inv;
    logic [LOG_N-1:0] row_sel;
    logic [LOG_N-1:0] col_sel;

`ifdef ROT_TILE_FLIP_EN
    assign j_eff = flip ? ~j : j;
`else
    assign j_eff = j;
`endif

    // N-1-x on a power-of-two field is just the bitwise inverse
    genvar gi;
    generate
        for (gi = 0; gi < LOG_N; gi++) begin : g_inv
            assign i_inv[gi] = ~i[gi];
            assign j_inv[gi] = ~j_eff[gi];
        end
    endgenerate

    // Select source row/column for the requested rotation
    always_comb begin
        row_sel = i;
        col_sel = j_eff;
        case (mode)
            ROT_MODE_0: begin
                row_sel = i;
                col_sel = j_eff;
            end
            ROT_MODE_90: begin
                row_sel = j_inv;
                col_sel = i;
            end
            ROT_MODE_180: begin
                row_sel = i_inv;
                col_sel = j_inv;
            end
            ROT_MODE_270: begin
                row_sel = j_eff;
                col_sel = i_inv;
            end
            default: begin
                row_sel = i;
                col_sel = j_eff;
            end
        endcase
    end

    assign src_idx = {row_sel, col_sel};

endmodule

// File: rtl/rot_tile_buffer.sv
// Tile buffer for the rotation engine. Accepts one TILE_N x TILE_N tile in
// raster order (FILL), then streams it back in raster order rotated by
// 0/90/180/270 degrees clockwise (DRAIN). The tile store is a single-port
// RAM: it is only written in FILL and only read in DRAIN, and the read
// data lands directly in the output register.
// Optional feature macro: ROT_TILE_FLIP_EN adds the I_FLIP port and a
// horizontal mirror applied before the rotation.
module rot_tile_buffer
    import rot_pkg::*;
#(
    parameter int PIX_W  = 32,
    parameter int TILE_N = 8
)(
    input  logic             I_HCLK,
    input  logic             I_HRESET_N,
    input  logic             I_START,
    input  logic [1:0]       I_MODE,
`ifdef ROT_TILE_FLIP_EN
    input  logic             I_FLIP,
`endif
    input  logic             I_CLR,
    input  logic             I_IN_VALID,
    input  logic [PIX_W-1:0] I_IN_DATA,
    output logic             O_IN_READY,
    output logic             O_OUT_VALID,
    output logic [PIX_W-1:0] O_OUT_DATA,
    input  logic             I_OUT_READY,
    output logic             O_BUSY,
    output logic             O_DONE
);

    localparam int LOG_N = rot_log2(TILE_N);
    localparam int AW    = 2 * LOG_N;
    localparam int DEPTH = TILE_N * TILE_N;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    rot_state_e       state_reg;
    rot_state_e       state_next;

    logic [1:0]       mode_reg;
`ifdef ROT_TILE_FLIP_EN
    logic             flip_reg;
`endif
    logic [AW-1:0]    wr_cnt_reg;
    logic [AW-1:0]    rd_cnt_reg;
    logic             rd_last_reg;   // final tile index has been read out
    logic             out_valid_reg;
    logic [PIX_W-1:0] out_data_reg;
    logic             done_reg;

    logic [PIX_W-1:0] mem [DEPTH];

    logic             fill_ready;
    logic             busy;
    logic             in_fire;
    logic             mem_we;
    logic             load_en;
    logic             out_fire;
    logic             last_out;
    logic [AW-1:0]    src_idx;
    logic [AW-1:0]    mem_addr;

    // Output position -> source index for the tile being drained
    rot_addr_map #(
        .LOG_N (LOG_N)
    ) u_addr_map (
        .i       (rd_cnt_reg[AW-1:LOG_N]),
        .j       (rd_cnt_reg[LOG_N-1:0]),
        .mode    (mode_reg),
`ifdef ROT_TILE_FLIP_EN
        .flip    (flip_reg),
`endif
        .src_idx (src_idx)
    );

    assign in_fire  = fill_ready && I_IN_VALID;
    assign mem_we   = in_fire && !I_CLR;
    assign out_fire = out_valid_reg && I_OUT_READY;
    // Refill the output stage while the read side still has pixels to issue
    assign load_en  = (state_reg == ST_DRAIN) && !rd_last_reg &&
                      (!out_valid_reg || I_OUT_READY);
    // The last beat is the one accepted after the final index was read
    assign last_out = (state_reg == ST_DRAIN) && rd_last_reg && out_fire;
    // One address port: write pointer while filling, mapped index otherwise
    assign mem_addr = (state_reg == ST_FILL) ? wr_cnt_reg : src_idx;

    // State register
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and state-decoded outputs; abort overrides everything
    always_comb begin
        state_next = state_reg;
        fill_ready = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ST_FILL: begin
                fill_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                fill_ready = 1'b0;
                busy       = 1'b0;
            end
        endcase

        if (I_CLR) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (I_START) begin
                        state_next = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (in_fire && (wr_cnt_reg == LAST_IDX)) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_out) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Tile store write port; contents survive abort and reset
    always_ff @(posedge I_HCLK) begin
        if (mem_we) begin
            mem[mem_addr] <= I_IN_DATA;
        end
    end

    // Per-run configuration, counters and the registered output stage
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            mode_reg      <= ROT_MODE_0;
`ifdef ROT_TILE_FLIP_EN
            flip_reg      <= 1'b0;
`endif
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            rd_last_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (I_CLR) begin
                wr_cnt_reg    <= '0;
                rd_cnt_reg    <= '0;
                rd_last_reg   <= 1'b0;
                out_valid_reg <= 1'b0;
            end else begin
                if ((state_reg == ST_IDLE) && I_START) begin
                    mode_reg    <= I_MODE;
`ifdef ROT_TILE_FLIP_EN
                    flip_reg    <= I_FLIP;
`endif
                    wr_cnt_reg  <= '0;
                    rd_cnt_reg  <= '0;
                    rd_last_reg <= 1'b0;
                end

                if (in_fire) begin
                    wr_cnt_reg <= wr_cnt_reg + AW'(1);
                end

                if (load_en) begin
                    out_data_reg  <= mem[mem_addr];
                    out_valid_reg <= 1'b1;
                    rd_cnt_reg    <= rd_cnt_reg + AW'(1);
                    if (rd_cnt_reg == LAST_IDX) begin
                        rd_last_reg <= 1'b1;
                    end
                end else if (last_out) begin
                    out_valid_reg <= 1'b0;
                    rd_last_reg   <= 1'b0;
                    done_reg      <= 1'b1;
                end
            end
        end
    end

    assign O_IN_READY  = fill_ready;
    assign O_BUSY      = busy;
    assign O_OUT_VALID = out_valid_reg;
    assign O_OUT_DATA  = out_data_reg;
    assign O_DONE      = done_reg;

endmodule

// File: tb/tb_rot_tile_buffer.sv
// Scoreboard bench for rot_tile_buffer with a 4x4 tile. Each run computes the
// rotated pixel order from (row, col) arithmetic and queues it; a negedge
// monitor pops and compares every accepted output beat. Deterministic 0..15
// tiles are also checked against hand-written rows.
module tb_rot_tile_buffer;

    localparam int N  = 4;
    localparam int NN = N * N;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_mode = 2'd0;
`ifdef ROT_TILE_FLIP_EN
    logic        i_flip = 1'b0;
`endif
    logic        i_clr = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [31:0] i_in_data = 32'd0;
    logic        i_out_ready = 1'b1;
    logic        o_in_ready;
    logic        o_out_valid;
    logic [31:0] o_out_data;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit rand_ready = 1'b0;
    bit stall_pending = 1'b0;
    logic [31:0] stall_data;
    logic [31:0] exp_q [$];
    logic [31:0] out_log [$];

    rot_tile_buffer #(
        .PIX_W  (32),
        .TILE_N (N)
    ) dut (
        .I_HCLK      (clk),
        .I_HRESET_N  (rst_n),
        .I_START     (i_start),
        .I_MODE      (i_mode),
`ifdef ROT_TILE_FLIP_EN
        .I_FLIP      (i_flip),
`endif
        .I_CLR       (i_clr),
        .I_IN_VALID  (i_in_valid),
        .I_IN_DATA   (i_in_data),
        .O_IN_READY  (o_in_ready),
        .O_OUT_VALID (o_out_valid),
        .O_OUT_DATA  (o_out_data),
        .I_OUT_READY (i_out_ready),
        .O_BUSY      (o_busy),
        .O_DONE      (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int k);
        if (k < out_log.size()) return out_log[k];
        return 'x;
    endfunction

    task automatic chk_row(input string name, input int base, input int a, input int b,
                           input int c, input int d);
        chk(name, log_at(base + 0), a);
        chk(name, log_at(base + 1), b);
        chk(name, log_at(base + 2), c);
        chk(name, log_at(base + 3), d);
    endtask

    // Downstream ready: held high or randomly toggled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, done pulses
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                chk("stall_valid", o_out_valid, 1);
                chk("stall_data", o_out_data, stall_data);
            end
            stall_pending = 1'b0;
            if (o_out_valid && !i_out_ready) begin
                stall_pending = 1'b1;
                stall_data = o_out_data;
            end
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected: got %0d, required no beat", o_out_data);
                end else begin
                    chk("beat_data", o_out_data, exp_q.pop_front());
                end
                out_log.push_back(o_out_data);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // One tile run: model, start, fill, then finish, abort or reset
    task automatic run_tile(input int mode, input bit flip, input bit seq, input bit gaps,
                            input bit noise, input bit rnd_rdy, input int clr_after,
                            input bit rst_drain, input bit chk_lat);
        logic [31:0] pix [NN];
        int i, j, sr, sc, w, guard, d0, start_cyc;
        bit eff_flip, acc;
`ifdef ROT_TILE_FLIP_EN
        eff_flip = flip;
`else
        eff_flip = 1'b0;
`endif
        for (int k = 0; k < NN; k++) pix[k] = seq ? 32'(k) : $urandom;
        for (int k = 0; k < NN; k++) begin
            i = k / N;
            j = k % N;
            if (eff_flip) j = N - 1 - j;
            case (mode)
                0: begin sr = i;         sc = j;         end
                1: begin sr = N - 1 - j; sc = i;         end
                2: begin sr = N - 1 - i; sc = N - 1 - j; end
                default: begin sr = j;   sc = N - 1 - i; end
            endcase
            exp_q.push_back(pix[sr * N + sc]);
        end
        out_log.delete();
        rand_ready = rnd_rdy;
        d0 = done_cnt;

        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_mode = 2'(mode);
`ifdef ROT_TILE_FLIP_EN
        i_flip = flip;
`endif
        start_cyc = cyc;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("fill_busy", o_busy, 1);
        chk("fill_in_ready", o_in_ready, 1);

        w = 0;
        guard = 0;
        while (w < NN && guard < 400) begin
            i_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_in_data = pix[w];
            if (noise) begin
                i_start = 1'($urandom_range(0, 1));
                i_mode = 2'($urandom_range(0, 3));
            end
            acc = i_in_valid && o_in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) w++;
            if (clr_after >= 0 && w == clr_after) break;
        end
        i_in_valid = 1'b0;
        i_start = 1'b0;
        i_mode = 2'(mode);

        if (clr_after >= 0) begin
            chk("clr_beats", w, clr_after);
            i_clr = 1'b1;
            @(posedge clk);
            #1;
            i_clr = 1'b0;
            exp_q.delete();
            chk("clr_busy", o_busy, 0);
            chk("clr_in_ready", o_in_ready, 0);
            chk("clr_out_valid", o_out_valid, 0);
            repeat (40) @(posedge clk);
            chk("clr_no_done", done_cnt, d0);
            $display("run mode=%0d aborted after %0d beats", mode, w);
            return;
        end

        chk("fill_beats", w, NN);
        chk("drain_in_ready", o_in_ready, 0);

        if (rst_drain) begin
            guard = 0;
            while (!o_out_valid && guard < 50) begin
                @(posedge clk);
                #1;
                guard++;
            end
            chk("drain_valid_seen", o_out_valid, 1);
            // a start while draining must not disturb the run
            i_start = 1'b1;
            i_mode = 2'(mode ^ 1);
            @(posedge clk);
            #1;
            i_start = 1'b0;
            i_mode = 2'(mode);
            repeat (2) @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            chk("arst_out_valid", o_out_valid, 0);
            chk("arst_out_data", o_out_data, 0);
            chk("arst_busy", o_busy, 0);
            chk("arst_done", o_done, 0);
            chk("arst_in_ready", o_in_ready, 0);
            exp_q.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("arst_idle", o_busy, 0);
            rand_ready = 1'b0;
            $display("run mode=%0d reset during drain after %0d beats out", mode, out_log.size());
            return;
        end

        guard = 0;
        while (done_cnt == d0 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("done_seen", done_cnt, d0 + 1);
        if (chk_lat) chk("latency", done_cyc - start_cyc + 1, 2 * NN + 3);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("beats_out", out_log.size(), NN);
        chk("idle_busy", o_busy, 0);
        rand_ready = 1'b0;
        $display("run mode=%0d flip=%0d beats_out=%0d done_cycle=%0d", mode, eff_flip,
                 out_log.size(), done_cyc - start_cyc);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Deterministic tiles with literal expectations
        run_tile(0, 0, 1, 0, 0, 0, -1, 0, 1);
        for (int k = 0; k < NN; k++) chk("m0_seq", log_at(k), k);
        run_tile(1, 0, 1, 0, 0, 0, -1, 0, 1);
        chk_row("m1_first_row", 0, 12, 8, 4, 0);
        chk_row("m1_last_row", 12, 15, 11, 7, 3);
        run_tile(2, 0, 1, 0, 0, 0, -1, 0, 1);
        for (int k = 0; k < NN; k++) chk("m2_seq", log_at(k), NN - 1 - k);
        run_tile(3, 0, 1, 0, 0, 0, -1, 0, 1);
        chk_row("m3_first_row", 0, 3, 7, 11, 15);
`ifdef ROT_TILE_FLIP_EN
        run_tile(0, 1, 1, 0, 0, 0, -1, 0, 1);
        chk_row("m0_flip_row", 0, 3, 2, 1, 0);
        run_tile(1, 1, 1, 0, 0, 0, -1, 0, 1);
        chk_row("m1_flip_row", 0, 0, 4, 8, 12);
`endif

        // Backpressure in mode 1
        run_tile(1, 0, 1, 0, 0, 1, -1, 0, 0);
        chk_row("m1_stall_row", 0, 12, 8, 4, 0);
        run_tile(1, 0, 0, 0, 0, 1, -1, 0, 0);

        // Abort after 8 input beats, then a fresh run
        run_tile(1, 0, 0, 0, 0, 0, 8, 0, 0);
        run_tile(3, 0, 0, 0, 0, 0, -1, 0, 1);

        // Randomised runs: gaps, random ready, start/mode noise while busy
        for (int r = 0; r < 8; r++) begin
            run_tile($urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 1, 1, 1, -1, 0, 0);
        end

        // Asynchronous reset in the middle of a drain, then recovery
        run_tile(2, 0, 0, 0, 0, 0, -1, 1, 0);
        run_tile(1, 0, 0, 0, 0, 0, -1, 0, 1);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
